// File: rtl/rotor_emulator.sv
// Quadrature step emulator: turns single-detent step requests into ROT_A/ROT_B
// sequences and tracks a signed detent count. Optional contact bounce via ROT_BOUNCE_EN.
module rotor_emulator #(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter int unsigned POS_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    output logic             ROT_A,
    output logic             ROT_B,
    output logic             busy,
    output logic             step_done,
    output logic [POS_W-1:0] position
);

    localparam int unsigned CntW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CntW-1:0] PhaseLast = CntW'(PHASE_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StP1, StP2, StP3, StP4} state_e;

`ifdef ROT_BOUNCE_EN
    if (PHASE_CYCLES < 8) begin : g_cfg_check
        $error("rotor_emulator: ROT_BOUNCE_EN needs PHASE_CYCLES >= 8");
    end
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [1:0]        ab_q, ab_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // {A,B} levels of a phase; dir=1 leads with B, dir=0 leads with A.
    function automatic logic [1:0] levels(input state_e st, input logic dir);
        logic [1:0] ab;
        case (st)
            StP1:    ab = dir ? 2'b01 : 2'b10;
            StP2:    ab = 2'b11;
            StP3:    ab = dir ? 2'b10 : 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

`ifdef ROT_BOUNCE_EN
    function automatic state_e prev_state(input state_e st);
        state_e p;
        case (st)
            StP2:    p = StP1;
            StP3:    p = StP2;
            StP4:    p = StP3;
            default: p = StIdle;
        endcase
        return p;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step_valid && ready_q) begin
                    state_d = StP1;
                    cnt_d   = '0;
                    dir_d   = step_dir;
                end
            end
            StP1, StP2, StP3, StP4: begin
                if (cnt_q == PhaseLast) begin
                    cnt_d = '0;
                    case (state_q)
                        StP1: begin
                            state_d = StP2;
                            // Count lands with the (1,1) phase the decoder uses.
                            pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                        end
                        StP2:    state_d = StP3;
                        StP3:    state_d = StP4;
                        default: begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        ab_d = levels(state_d, dir_d);
`ifdef ROT_BOUNCE_EN
        // Odd cycles 1 and 3 of a phase fall back to the previous phase's levels.
        if (state_d != StIdle && cnt_d < CntW'(4) && cnt_d[0]) begin
            ab_d = levels(prev_state(state_d), dir_d);
        end
`endif
        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= '0;
            ab_q    <= 2'b00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            ab_q    <= ab_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ROT_A      = ab_q[1];
    assign ROT_B      = ab_q[0];
    assign step_ready = ready_q;
    assign busy       = busy_q;
    assign step_done  = done_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_rotor_emulator.sv
// Scoreboard bench for rotor_emulator; define ROT_BOUNCE_EN to exercise bounce with PHASE_CYCLES=8.
module tb_rotor_emulator;

`ifdef ROT_BOUNCE_EN
    localparam int PC = 8;
`else
    localparam int PC = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_valid = 1'b0;
    logic       step_dir = 1'b0;
    logic       step_ready, ROT_A, ROT_B, busy, step_done;
    logic [7:0] position;

    rotor_emulator #(.PHASE_CYCLES(PC), .POS_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .step_ready (step_ready),
        .ROT_A      (ROT_A),
        .ROT_B      (ROT_B),
        .busy       (busy),
        .step_done  (step_done),
        .position   (position)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dir;
        logic [7:0] old_p;
        logic [7:0] new_p;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] model_pos = 8'd0;
    int         tests = 0;
    int         fails = 0;
    int         idx = 0;
    int         seq_err = 0;
    logic       pa = 1'b0, pb = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {A,B} for busy cycle i of a step, from the hand tables.
    function automatic logic [1:0] exp_lvl(input logic dir, input int i);
        int p;
        int c;
        int sel;
        p   = i / PC + 1;
        c   = i % PC;
        sel = p;
`ifdef ROT_BOUNCE_EN
        if (c < 4 && (c % 2) == 1) sel = p - 1;
`endif
        case (sel)
            1:       return dir ? 2'b01 : 2'b10;
            2:       return 2'b11;
            3:       return dir ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic push(input logic dir);
        logic [7:0] nxt;
        nxt = dir ? model_pos + 8'd1 : model_pos - 8'd1;
        sb.push_back(exp_t'{dir, model_pos, nxt});
        model_pos = nxt;
    endtask

    // Monitor: checks levels per busy cycle, pops and compares on step_done.
    always @(negedge clk) begin
        if (rst) begin
            idx = 0;
            seq_err = 0;
            pa = 1'b0;
            pb = 1'b0;
        end else begin
            if (ROT_A !== pa || ROT_B !== pb)
                check("one_line_change", 32'(ROT_A !== pa && ROT_B !== pb), 0);
            pa = ROT_A;
            pb = ROT_B;
            if (busy) begin
                if (sb.size() == 0) begin
                    check("spurious_busy", 1, 0);
                end else begin
                    if (idx < 4 * PC && {ROT_A, ROT_B} !== exp_lvl(sb[0].dir, idx)) seq_err++;
                    if (idx == PC - 1) check("pos_before_p2", 32'(position), 32'(sb[0].old_p));
                    if (idx == PC) check("pos_at_p2", 32'(position), 32'(sb[0].new_p));
                end
                idx++;
            end
            if (step_done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("busy_len", idx, 4 * PC);
                    check("ab_sequence_errs", seq_err, 0);
                    check("pos_on_done", 32'(position), 32'(mon_e.new_p));
                    check("ready_on_done", 32'(step_ready), 1);
                    check("idle_levels", 32'({ROT_A, ROT_B}), 0);
                end
                idx = 0;
                seq_err = 0;
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!step_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!step_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_step(input logic dir);
        @(negedge clk);
        wait_ready();
        step_valid = 1'b1;
        step_dir   = dir;
        @(posedge clk);
        push(dir);
        #1 step_valid = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        wait_ready();
    endtask

    initial begin
        #5 rst = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_a", 32'(ROT_A), 0);
        check("rst_b", 32'(ROT_B), 0);
        check("rst_ready", 32'(step_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(step_done), 0);
        check("rst_pos", 32'(position), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        do_step(1'b1);
        wait_idle();
        check("pos_one", 32'(position), 32'h01);

        // Three dir=0 steps with step_valid held high.
        begin
            int acc;
            int n;
            logic r;
            logic d;
            acc = 0;
            n = 0;
            @(negedge clk);
            wait_ready();
            step_valid = 1'b1;
            step_dir   = 1'b0;
            while (acc < 3 && n < 400) begin
                r = step_ready;
                d = step_done;
                @(posedge clk);
                if (r) begin
                    push(1'b0);
                    if (acc > 0) check("b2b_accept_on_done", 32'(d), 1);
                    acc++;
                    if (acc == 3) #1 step_valid = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            step_valid = 1'b0;
            check("b2b_accepts", acc, 3);
        end
        wait_idle();
        check("pos_b2b", 32'(position), 32'hFE);

        while (model_pos != 8'd127) do_step(1'b1);
        wait_idle();
        check("pos_127", 32'(position), 32'h7F);
        do_step(1'b1);
        wait_idle();
        check("pos_wrap_up", 32'(position), 32'h80);
        do_step(1'b0);
        wait_idle();
        check("pos_wrap_down", 32'(position), 32'h7F);

        // Request pulsed during P2 must be dropped.
        do_step(1'b0);
        repeat (PC + 1) @(negedge clk);
        step_valid = 1'b1;
        step_dir   = 1'b1;
        @(negedge clk);
        step_valid = 1'b0;
        wait_idle();
        check("pos_ignore_busy", 32'(position), 32'h7E);
        repeat (3) @(negedge clk);
        check("no_queued_step", 32'(busy), 0);

        // Asynchronous reset during P3.
        do_step(1'b1);
        repeat (2 * PC + 1) @(negedge clk);
        check("in_p3", 32'({ROT_A, ROT_B}), 32'b10);
        #2 rst = 1'b1;
        #1;
        check("arst_a", 32'(ROT_A), 0);
        check("arst_b", 32'(ROT_B), 0);
        check("arst_pos", 32'(position), 0);
        check("arst_ready", 32'(step_ready), 1);
        check("arst_busy", 32'(busy), 0);
        sb.delete();
        model_pos = 8'd0;
        @(negedge clk);
        #2 rst = 1'b0;
        do_step(1'b1);
        wait_idle();
        check("pos_after_rst", 32'(position), 32'h01);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
